// File: rtl/vga_dec.sv
// vga_dec: decodes a linear framebuffer address into pixel coordinates.
//   posx = eff mod WIDTH, posy = eff / WIDTH (low 9 bits)
// Computed with a 16-iteration restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on both sides.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   eff        linear address to decode (16 bits)
//   in_valid   eff is valid this cycle
//   in_ready   block is idle and can accept an address
//   posx       decoded x coordinate (remainder)
//   posy       decoded y coordinate (quotient, low 9 bits)
//   err        address lies outside the WIDTH*HEIGHT frame
//   out_valid  posx/posy/err are valid
//   out_ready  consumer accepts the result
//
// Build option: ADDR_DEC_RANGE_CHECK_EN
//   defined   -> err flags eff >= WIDTH*HEIGHT, registered with posx/posy
//   undefined -> err is tied 0, no compare logic exists
//
// State table:
//   state   | meaning
//   ST_IDLE | in_ready=1, waiting for an address
//   ST_CALC | 16 divider iterations, inputs ignored
//   ST_DONE | out_valid=1, result held until out_ready

module vga_dec #(
  parameter int WIDTH  = 200,
  parameter int HEIGHT = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] eff,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [8:0]  posx,
  output logic [8:0]  posy,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [9:0] WIDTH_C = 10'(WIDTH);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // Dividend and quotient share one shift register: dividend bits leave at
  // the top while quotient bits enter at the bottom. After 16 shifts it holds
  // the full 16-bit quotient.
  logic [15:0] dq_q, dq_d;
  // The remainder is always < WIDTH <= 511, so 9 stored bits suffice; the
  // 10th bit only exists transiently in rem_shift.
  logic [8:0]  rem_q, rem_d;
  logic [8:0]  posx_q, posx_d;
  logic [8:0]  posy_q, posy_d;

  logic [9:0]  rem_shift;
  logic        q_bit;
  logic [9:0]  rem_next;
  logic [15:0] quot_next;
  logic        last_iter;

  always_comb begin
    rem_shift = {rem_q, dq_q[15]};
    q_bit     = (rem_shift >= WIDTH_C);
    rem_next  = q_bit ? (rem_shift - WIDTH_C) : rem_shift;
    quot_next = {dq_q[14:0], q_bit};
    last_iter = (state_q == ST_CALC) && (cnt_q == 4'd15);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dq_d    = eff;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        dq_d  = quot_next;
        rem_d = rem_next[8:0];
        cnt_d = cnt_q + 4'd1;
        if (last_iter) begin
          posx_d  = rem_next[8:0];
          posy_d  = quot_next[8:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      posx_q  <= '0;
      posy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
    end
  end

`ifdef ADDR_DEC_RANGE_CHECK_EN
  localparam logic [16:0] FRAME_C = 17'(WIDTH * HEIGHT);

  // The dividend register is consumed by the shifts, so the out-of-frame
  // decision is taken at accept time and carried until the result is stored.
  logic range_q, range_d;
  logic err_q, err_d;

  always_comb begin
    range_d = range_q;
    err_d   = err_q;
    if (state_q == ST_IDLE && in_valid) range_d = ({1'b0, eff} >= FRAME_C);
    if (last_iter) err_d = range_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      range_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      range_q <= range_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign posx      = posx_q;
  assign posy      = posy_q;

endmodule

// File: tb/tb_vga_dec.sv
module tb_vga_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] eff;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  posx;
  logic [8:0]  posy;
  logic        err;
  logic        out_valid;
  logic        out_ready;

`ifdef ADDR_DEC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  vga_dec #(.WIDTH(200), .HEIGHT(150)) dut (
    .clk(clk), .rst(rst), .eff(eff), .in_valid(in_valid), .in_ready(in_ready),
    .posx(posx), .posy(posy), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: plain integer division of the address by the line width.
  function automatic void model(input int e, output int mx, output int my, output int me);
    mx = e % 200;
    my = (e / 200) % 512;
    me = (RC && e >= 200 * 150) ? 1 : 0;
  endfunction

  // Wait (bounded) for in_ready, present one address, return after the accept edge.
  task automatic send(input logic [15:0] e, output int acc, output bit to);
    int n = 0;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    to = !in_ready;
    eff = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit to);
    lat = 0;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    to = !out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; eff = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, posx, posy, err} !== {1'b1, 1'b0, 9'd0, 9'd0, 1'b0})
      $display("FAIL reset: rdy=%b ov=%b x=%0d y=%0d err=%b, want rdy=1 ov=0 x=0 y=0 err=0",
               in_ready, out_valid, posx, posy, err);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency_zero();
    int acc, lat; bit to1, to2;
    out_ready = 1'b1;
    send(16'd0, acc, to1);
    wait_out(lat, to2);
    n_checks++;
    if (to1 || to2 || lat != 16)
      $display("FAIL latency: out_valid after %0d cycles past accept+1 (timeout %b/%b), want 16", lat, to1, to2);
    else n_pass++;
    n_checks++;
    if ({posx, posy, err} !== {9'd0, 9'd0, 1'b0})
      $display("FAIL zero_addr: x=%0d y=%0d err=%b, want 0 0 0", posx, posy, err);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL after_hs: rdy=%b ov=%b, want rdy=1 ov=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_points();
    int pts[8] = '{215, 29999, 199, 200, 30000, 65535, 1, 12345};
    int mx, my, me, acc, lat; bit to1, to2;
    out_ready = 1'b1;
    foreach (pts[i]) begin
      model(pts[i], mx, my, me);
      send(16'(pts[i]), acc, to1);
      wait_out(lat, to2);
      n_checks++;
      if (to1 || to2 || posx !== 9'(mx) || posy !== 9'(my) || err !== 1'(me))
        $display("FAIL point eff=%0d: x=%0d y=%0d err=%b to=%b%b, want x=%0d y=%0d err=%0d",
                 pts[i], posx, posy, err, to1, to2, mx, my, me);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep();
    int e, mx, my, me, acc, lat; bit to1, to2;
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      e = (k < 16) ? int'($urandom_range(0, 29999)) : int'($urandom_range(30000, 65535));
      model(e, mx, my, me);
      send(16'(e), acc, to1);
      wait_out(lat, to2);
      n_checks++;
      if (to1 || to2 || posx !== 9'(mx) || posy !== 9'(my) || err !== 1'(me) ||
          (e < 30000 && int'(posy) * 200 + int'(posx) != e))
        $display("FAIL sweep eff=%0d: x=%0d y=%0d err=%b, want x=%0d y=%0d err=%0d",
                 e, posx, posy, err, mx, my, me);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    int acc, lat; bit to1, to2, bad;
    out_ready = 1'b0;
    send(16'd1000, acc, to1);
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = k[0];
      eff = 16'($urandom);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad) $display("FAIL calc_busy: in_ready/out_valid asserted during CALC, want 0/0");
    else n_pass++;
    wait_out(lat, to2);
    n_checks++;
    if (to1 || to2) $display("FAIL hold_timeout: result never appeared, want out_valid=1");
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      eff = 16'($urandom);
      n_checks++;
      if ({out_valid, in_ready, posx, posy} !== {1'b1, 1'b0, 9'd0, 9'd5})
        $display("FAIL hold cyc%0d: ov=%b rdy=%b x=%0d y=%0d, want ov=1 rdy=0 x=0 y=5",
                 k, out_valid, in_ready, posx, posy);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL hold_release: ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc, lat; bit to1, to2, seen;
    out_ready = 1'b1;
    send(16'd500, acc, to1);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, posx, posy} !== {1'b1, 1'b0, 9'd0, 9'd0})
      $display("FAIL mid_reset: rdy=%b ov=%b x=%0d y=%0d, want rdy=1 ov=0 x=0 y=0",
               in_ready, out_valid, posx, posy);
    else n_pass++;
    seen = 1'b0;
    repeat (20) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen) $display("FAIL abandoned: out_valid=1 after reset, want 0");
    else n_pass++;
    send(16'd399, acc, to1);
    wait_out(lat, to2);
    n_checks++;
    if (to1 || to2 || lat != 16 || posx !== 9'd199 || posy !== 9'd1)
      $display("FAIL post_reset: x=%0d y=%0d lat=%0d, want x=199 y=1 lat=16", posx, posy, lat);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int v[5];
    int mx, my, me, acc, prev, lat, n; bit to;
    foreach (v[i]) v[i] = int'($urandom_range(0, 65535));
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    eff = 16'(v[0]);
    in_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: in_ready=%b, want 1", i, in_ready);
      else n_pass++;
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) begin
        n_checks++;
        if (acc - prev != 18) $display("FAIL b2b_interval%0d: %0d cycles, want 18", i, acc - prev);
        else n_pass++;
      end
      prev = acc;
      eff = (i < 4) ? 16'(v[i+1]) : 16'($urandom);
      if (i == 4) in_valid = 1'b0;
      wait_out(lat, to);
      model(v[i], mx, my, me);
      n_checks++;
      if (to || lat != 16 || posx !== 9'(mx) || posy !== 9'(my) || err !== 1'(me))
        $display("FAIL b2b_result%0d eff=%0d: x=%0d y=%0d err=%b lat=%0d, want x=%0d y=%0d err=%0d lat=16",
                 i, v[i], posx, posy, err, lat, mx, my, me);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency_zero();
    test_points();
    test_sweep();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
